// File: rtl/grid_game_pkg.sv
// grid_game_pkg: shared state, tile-code and direction encodings plus the LFSR step
// used by the grid game engine.
package grid_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PLACE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  localparam logic [1:0] PIC_GIFT   = 2'b00;
  localparam logic [1:0] PIC_GRINCH = 2'b01;
  localparam logic [1:0] PIC_WALL   = 2'b10;
  localparam logic [1:0] PIC_EMPTY  = 2'b11;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/grid_lfsr.sv
// grid_lfsr: free-running 16-bit Fibonacci LFSR with seed load.
// A zero seed would lock the register up, so it is replaced by the reset constant.
module grid_lfsr
  import grid_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;

  // Shift every cycle; a load request takes priority over the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_INIT;
    end else if (load) begin
      lfsr_r <= (seed == 16'h0000) ? LFSR_INIT : seed;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/grid_game_core.sv
// grid_game_core: grinch/gift/wall tile game engine with a registered per-pixel tile lookup.
// Build macro WRAP_EN makes the grinch wrap around grid edges instead of losing the game.
module grid_game_core
  import grid_game_pkg::*;
#(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int TILE_SHIFT = 4,
  parameter int WIN_COUNT  = 10,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int CW = $clog2(WIN_COUNT + 1)
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          update_tick,
  input  logic          start,
  input  logic [1:0]    direction,
  input  logic [15:0]   seed,
  input  logic [9:0]    x_in,
  input  logic [8:0]    y_in,
  output logic [1:0]    pic_type,
  output logic          game_over,
  output logic          game_win,
  output logic [CW-1:0] gift_count
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int IW    = $clog2(NCELL);

  localparam logic [XW-1:0] HOME_X  = XW'(GRID_W / 2);
  localparam logic [YW-1:0] HOME_Y  = YW'(GRID_H / 2);
  localparam logic [XW-1:0] GIFT0_X = XW'(GRID_W / 2 + 4);
  localparam logic [XW-1:0] MAX_X   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] MAX_Y   = YW'(GRID_H - 1);
  localparam logic [XW:0]   LIM_X   = (XW + 1)'(GRID_W);
  localparam logic [YW:0]   LIM_Y   = (YW + 1)'(GRID_H);

  state_t            state_r;
  logic [XW-1:0]     gx_r, fx_r, nx_s, cx_s, tx_s;
  logic [YW-1:0]     gy_r, fy_r, ny_s, cy_s, ty_s;
  logic              gift_valid_r;
  logic [NCELL-1:0]  wall_r;
  logic [15:0]       lfsr_s;
  logic              lfsr_load_s, unused_lfsr_s;
  logic              off_edge_s, nxt_wall_s, hit_gift_s;
  logic              cand_in_s, cand_ok_s, pix_in_s;
  logic [IW-1:0]     cand_idx_s, pix_idx_s;
  logic [CW-1:0]     count_nxt_s;
  logic [9:0]        tile_x_s;
  logic [8:0]        tile_y_s;
  logic [1:0]        pic_s;

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(y) * IW'(GRID_W) + IW'(x);
  endfunction

  assign lfsr_load_s   = (state_r == ST_IDLE) && start;
  assign unused_lfsr_s = ^lfsr_s;

  grid_lfsr u_lfsr (
    .clk   (vga_clk),
    .rst_n (reset),
    .load  (lfsr_load_s),
    .seed  (seed),
    .value (lfsr_s)
  );

  // Next grinch cell for the current direction, flagging moves off the grid.
  always_comb begin
    nx_s       = gx_r;
    ny_s       = gy_r;
    off_edge_s = 1'b0;
    case (direction)
      DIR_LEFT: begin
        if (gx_r == XW'(0)) begin
`ifdef WRAP_EN
          nx_s = MAX_X;
`else
          off_edge_s = 1'b1;
`endif
        end else begin
          nx_s = gx_r - XW'(1);
        end
      end
      DIR_UP: begin
        if (gy_r == YW'(0)) begin
`ifdef WRAP_EN
          ny_s = MAX_Y;
`else
          off_edge_s = 1'b1;
`endif
        end else begin
          ny_s = gy_r - YW'(1);
        end
      end
      DIR_RIGHT: begin
        if (gx_r == MAX_X) begin
`ifdef WRAP_EN
          nx_s = XW'(0);
`else
          off_edge_s = 1'b1;
`endif
        end else begin
          nx_s = gx_r + XW'(1);
        end
      end
      default: begin
        if (gy_r == MAX_Y) begin
`ifdef WRAP_EN
          ny_s = YW'(0);
`else
          off_edge_s = 1'b1;
`endif
        end else begin
          ny_s = gy_r + YW'(1);
        end
      end
    endcase
  end

  assign nxt_wall_s  = wall_r[cell_idx(nx_s, ny_s)];
  assign hit_gift_s  = gift_valid_r && (nx_s == fx_r) && (ny_s == fy_r);
  assign count_nxt_s = gift_count + CW'(1);

  // Rejection sampling: the raw LFSR slices may fall outside the grid.
  assign cx_s       = lfsr_s[XW-1:0];
  assign cy_s       = lfsr_s[8+YW-1:8];
  assign cand_in_s  = ({1'b0, cx_s} < LIM_X) && ({1'b0, cy_s} < LIM_Y);
  assign cand_idx_s = cand_in_s ? cell_idx(cx_s, cy_s) : IW'(0);
  assign cand_ok_s  = cand_in_s && !wall_r[cand_idx_s] && !((cx_s == gx_r) && (cy_s == gy_r));

  // Game state machine with its registered status outputs.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      gx_r         <= HOME_X;
      gy_r         <= HOME_Y;
      fx_r         <= GIFT0_X;
      fy_r         <= HOME_Y;
      gift_valid_r <= 1'b1;
      wall_r       <= {NCELL{1'b0}};
      gift_count   <= {CW{1'b0}};
      game_over    <= 1'b0;
      game_win     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (update_tick) begin
            if (off_edge_s || nxt_wall_s) begin
              state_r <= ST_LOSE;
            end else begin
              gx_r <= nx_s;
              gy_r <= ny_s;
              if (hit_gift_s) begin
                wall_r[cell_idx(gx_r, gy_r)] <= 1'b1;
                gift_count   <= count_nxt_s;
                gift_valid_r <= 1'b0;
                state_r      <= (count_nxt_s == CW'(WIN_COUNT)) ? ST_WIN : ST_PLACE;
              end
            end
          end
        end
        ST_PLACE: begin
          if (cand_ok_s) begin
            fx_r         <= cx_s;
            fy_r         <= cy_s;
            gift_valid_r <= 1'b1;
            state_r      <= ST_RUN;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (start) begin
            state_r      <= ST_IDLE;
            gx_r         <= HOME_X;
            gy_r         <= HOME_Y;
            fx_r         <= GIFT0_X;
            fy_r         <= HOME_Y;
            gift_valid_r <= 1'b1;
            wall_r       <= {NCELL{1'b0}};
            gift_count   <= {CW{1'b0}};
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      game_over <= (state_r == ST_LOSE);
      game_win  <= (state_r == ST_WIN);
    end
  end

  assign tile_x_s  = x_in >> TILE_SHIFT;
  assign tile_y_s  = y_in >> TILE_SHIFT;
  assign pix_in_s  = (tile_x_s < 10'(GRID_W)) && (tile_y_s < 9'(GRID_H));
  assign tx_s      = tile_x_s[XW-1:0];
  assign ty_s      = tile_y_s[YW-1:0];
  assign pix_idx_s = pix_in_s ? cell_idx(tx_s, ty_s) : IW'(0);

  // Tile classification for the pixel under the beam, highest priority first.
  always_comb begin
    pic_s = PIC_EMPTY;
    if (!pix_in_s) begin
      pic_s = PIC_EMPTY;
    end else if ((tx_s == gx_r) && (ty_s == gy_r)) begin
      pic_s = PIC_GRINCH;
    end else if (gift_valid_r && (tx_s == fx_r) && (ty_s == fy_r)) begin
      pic_s = PIC_GIFT;
    end else if (wall_r[pix_idx_s]) begin
      pic_s = PIC_WALL;
    end else begin
      pic_s = PIC_EMPTY;
    end
  end

  // One-cycle registered tile code towards the renderer.
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      pic_type <= PIC_EMPTY;
    end else begin
      pic_type <= pic_s;
    end
  end

endmodule

// File: tb/tb_grid_game_core.sv
// tb_grid_game_core: directed self-checking bench for grid_game_core; gift placement is
// predicted with an independent LFSR model and a small grid model used for route planning.
module tb_grid_game_core;

  localparam int GW = 40;
  localparam int GH = 30;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b0;
  logic        update_tick = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  direction = 2'b00;
  logic [15:0] seed = 16'h0000;
  logic [9:0]  x_in = 10'd0;
  logic [8:0]  y_in = 9'd0;
  logic [1:0]  pic_type;
  logic        game_over;
  logic        game_win;
  logic [3:0]  gift_count;

  int total = 0;
  int bad = 0;

  grid_game_core dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .update_tick (update_tick),
    .start       (start),
    .direction   (direction),
    .seed        (seed),
    .x_in        (x_in),
    .y_in        (y_in),
    .pic_type    (pic_type),
    .game_over   (game_over),
    .game_win    (game_win),
    .gift_count  (gift_count)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference game model.
  logic [15:0] mdl_lfsr;
  bit          mdl_load = 1'b0;
  int          gx, gy, fx, fy, cnt;
  bit          gvalid;
  bit          walls [GH][GW];
  bit [1:0]    path_q [$];
  bit [1:0]    best_q [$];
  int          bx, by, bhits;
  bit          bgood;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  always @(posedge vga_clk or negedge reset) begin
    if (!reset) mdl_lfsr <= 16'hACE1;
    else if (mdl_load) mdl_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
    else mdl_lfsr <= lfsr_nx(mdl_lfsr);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic model_reset();
    gx = 20; gy = 15; fx = 24; fy = 15; gvalid = 1'b1; cnt = 0;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) walls[y][x] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; update_tick = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc();
    model_reset();
  endtask

  task automatic do_start(input logic [15:0] s);
    seed = s; start = 1'b1; mdl_load = 1'b1;
    cyc();
    start = 1'b0; mdl_load = 1'b0;
    cyc();
  endtask

  task automatic show_tile(input int tx, input int ty);
    x_in = 10'(tx * 16);
    y_in = 9'(ty * 16);
    cyc();
  endtask

  task automatic raw_tick(input logic [1:0] d);
    direction = d; update_tick = 1'b1;
    cyc();
    update_tick = 1'b0;
  endtask

  // Called just after the collecting edge: walk the LFSR sequence until a legal cell.
  task automatic predict_place();
    logic [15:0] v;
    int cx, cy;
    v = mdl_lfsr;
    for (int k = 0; k < 2000; k++) begin
      cx = int'(v[5:0]);
      cy = int'(v[12:8]);
      if (cx < GW && cy < GH && !walls[cy][cx] && !(cx == gx && cy == gy)) begin
        fx = cx; fy = cy; gvalid = 1'b1;
        cyc(k + 2);
        break;
      end
      v = lfsr_nx(v);
    end
  endtask

  task automatic do_move(input bit [1:0] d, output bit got, output bit lose);
    int nx, ny;
    nx = gx; ny = gy; got = 1'b0; lose = 1'b0;
    case (d)
      2'b00: nx--;
      2'b01: ny--;
      2'b10: nx++;
      default: ny++;
    endcase
    raw_tick(d);
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) lose = 1'b1;
    else if (walls[ny][nx]) lose = 1'b1;
    else begin
      if (gvalid && nx == fx && ny == fy) begin
        walls[gy][gx] = 1'b1; cnt++; gvalid = 1'b0; got = 1'b1;
      end
      gx = nx; gy = ny;
      if (got && cnt != 10) predict_place();
    end
    cyc();
  endtask

  task automatic walk(input bit [1:0] d);
    case (d)
      2'b00: bx--;
      2'b01: by--;
      2'b10: bx++;
      default: by++;
    endcase
    path_q.push_back(d);
    if (walls[by][bx]) bgood = 1'b0;
    if (bx == fx && by == fy) bhits++;
  endtask

  task automatic go_x(input int t);
    while (bx != t) walk((bx < t) ? 2'b10 : 2'b00);
  endtask

  task automatic go_y(input int t);
    while (by != t) walk((by < t) ? 2'b11 : 2'b01);
  endtask

  // Shortest wall-free three-leg route to the gift that touches the gift only at the end.
  task automatic route(output bit ok);
    int best;
    best = 100000; ok = 1'b0;
    for (int vf = 0; vf < 2; vf++) begin
      for (int m = 0; m < ((vf == 1) ? GH : GW); m++) begin
        path_q.delete();
        bx = gx; by = gy; bhits = 0; bgood = 1'b1;
        if (vf == 1) begin go_y(m); go_x(fx); go_y(fy); end
        else begin go_x(m); go_y(fy); go_x(fx); end
        if (bgood && bhits == 1 && path_q.size() < best) begin
          best = path_q.size(); best_q = path_q; ok = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(2);
    total++; if (pic_type !== 2'b11) begin bad++; $display("FAIL reset_pic: got %b want 11", pic_type); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_over: got %b want 0", game_over); end
    total++; if (game_win !== 1'b0) begin bad++; $display("FAIL reset_win: got %b want 0", game_win); end
    total++; if (gift_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", gift_count); end
    reset = 1'b1;
    cyc();
    model_reset();
  endtask

  task automatic test_pixels();
    x_in = 10'd320; y_in = 9'd240; cyc();
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL pix_grinch: got %b want 01", pic_type); end
    x_in = 10'd650; y_in = 9'd100; cyc();
    total++; if (pic_type !== 2'b11) begin bad++; $display("FAIL pix_off_x: got %b want 11", pic_type); end
    x_in = 10'd16; y_in = 9'd496; cyc();
    total++; if (pic_type !== 2'b11) begin bad++; $display("FAIL pix_off_y: got %b want 11", pic_type); end
    show_tile(24, 15);
    total++; if (pic_type !== 2'b00) begin bad++; $display("FAIL pix_gift0: got %b want 00", pic_type); end
    show_tile(5, 5);
    total++; if (pic_type !== 2'b11) begin bad++; $display("FAIL pix_empty: got %b want 11", pic_type); end
  endtask

  task automatic test_collect();
    bit got, lose;
    do_start(16'hBEEF);
    raw_tick(2'b10); cyc();
    total++; if (gift_count !== 4'd0) begin bad++; $display("FAIL idle_tick_count: got %0d want 0", gift_count); end
    gx = 21;
    for (int i = 0; i < 3; i++) do_move(2'b10, got, lose);
    total++; if (!got || gift_count !== 4'd1) begin bad++; $display("FAIL collect_count: got %0d want 1", gift_count); end
    x_in = 10'd368; y_in = 9'd240; cyc();
    total++; if (pic_type !== 2'b10) begin bad++; $display("FAIL collect_wall: got %b want 10", pic_type); end
    show_tile(24, 15);
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL collect_grinch: got %b want 01", pic_type); end
    show_tile(fx, fy);
    total++; if (pic_type !== 2'b00) begin bad++; $display("FAIL collect_new_gift (%0d,%0d): got %b want 00", fx, fy, pic_type); end
  endtask

  task automatic test_wall_lose();
    raw_tick(2'b00);
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL lose_latency: got %b want 0", game_over); end
    cyc();
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL lose_over: got %b want 1", game_over); end
    raw_tick(2'b01); cyc();
    show_tile(24, 15);
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL lose_hold: got %b want 01", pic_type); end
    total++; if (gift_count !== 4'd1) begin bad++; $display("FAIL lose_count: got %0d want 1", gift_count); end
  endtask

  task automatic test_edge();
    bit got, lose;
    do_reset();
    do_start(16'h5A5A);
    for (int i = 0; i < 20; i++) do_move(2'b00, got, lose);
    raw_tick(2'b00); cyc();
`ifdef WRAP_EN
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL wrap_over: got %b want 0", game_over); end
    show_tile(39, 15);
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL wrap_pos: got %b want 01", pic_type); end
`else
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL edge_over: got %b want 1", game_over); end
    show_tile(0, 15);
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL edge_hold: got %b want 01", pic_type); end
`endif
  endtask

  task automatic test_reset_mid_place();
    bit got, lose;
    do_reset();
    do_start(16'h1357);
    for (int i = 0; i < 3; i++) do_move(2'b10, got, lose);
    direction = 2'b10; update_tick = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    total++; if (pic_type !== 2'b11) begin bad++; $display("FAIL midrst_pic: got %b want 11", pic_type); end
    total++; if (gift_count !== 4'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", gift_count); end
    total++; if (game_over !== 1'b0 || game_win !== 1'b0) begin bad++; $display("FAIL midrst_status: got %b%b want 00", game_over, game_win); end
    cyc(2);
    update_tick = 1'b0; reset = 1'b1;
    cyc();
    model_reset();
    show_tile(23, 15);
    total++; if (pic_type !== 2'b11) begin bad++; $display("FAIL midrst_nowall: got %b want 11", pic_type); end
    show_tile(24, 15);
    total++; if (pic_type !== 2'b00) begin bad++; $display("FAIL midrst_gift: got %b want 00", pic_type); end
    show_tile(20, 15);
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL midrst_grinch: got %b want 01", pic_type); end
    do_start(16'h0000);
    for (int i = 0; i < 4; i++) do_move(2'b10, got, lose);
    total++; if (gift_count !== 4'd1) begin bad++; $display("FAIL restart_count: got %0d want 1", gift_count); end
    show_tile(fx, fy);
    total++; if (pic_type !== 2'b00) begin bad++; $display("FAIL restart_seed0_gift (%0d,%0d): got %b want 00", fx, fy, pic_type); end
  endtask

  task automatic test_win();
    bit got, lose, ok;
    do_reset();
    do_start(16'h1234);
    for (int g = 1; g <= 10; g++) begin
      route(ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL win_route: got no path to (%0d,%0d) want a path", fx, fy);
        break;
      end
      foreach (best_q[i]) do_move(best_q[i], got, lose);
      total++; if (gift_count !== 4'(g)) begin bad++; $display("FAIL win_count: got %0d want %0d", gift_count, g); end
      if (g < 10) begin
        show_tile(fx, fy);
        total++; if (pic_type !== 2'b00) begin bad++; $display("FAIL win_gift%0d (%0d,%0d): got %b want 00", g, fx, fy, pic_type); end
      end
    end
    total++; if (game_win !== 1'b1 || game_over !== 1'b0) begin bad++; $display("FAIL win_flag: got win=%b over=%b want 1 0", game_win, game_over); end
    raw_tick(2'b01); cyc();
    total++; if (gift_count !== 4'd10 || game_win !== 1'b1) begin bad++; $display("FAIL win_hold: got count=%0d win=%b want 10 1", gift_count, game_win); end
    show_tile(gx, gy);
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL win_grinch_hold: got %b want 01", pic_type); end
    start = 1'b1; cyc(); start = 1'b0; cyc();
    model_reset();
    total++; if (game_win !== 1'b0 || gift_count !== 4'd0) begin bad++; $display("FAIL win_to_idle: got win=%b count=%0d want 0 0", game_win, gift_count); end
    show_tile(23, 15);
    total++; if (pic_type !== 2'b11) begin bad++; $display("FAIL win_walls_cleared: got %b want 11", pic_type); end
    show_tile(20, 15);
    total++; if (pic_type !== 2'b01) begin bad++; $display("FAIL win_home: got %b want 01", pic_type); end
    show_tile(24, 15);
    total++; if (pic_type !== 2'b00) begin bad++; $display("FAIL win_gift_reset: got %b want 00", pic_type); end
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_collect();
    test_wall_lose();
    test_edge();
    test_reset_mid_place();
    test_win();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
